// File: rtl/status_led_pkg.sv
// status_led_pkg: shared definitions for the multi-channel LED status controller.
//
// Contents:
//   MODE_W     - width of one channel's mode field
//   LED_OFF    - channel dark
//   LED_ON     - channel lit (subject to PWM)
//   LED_BLINK  - channel follows the shared blink phase
//   LED_PULSE  - channel lit while its activity pulse counter is running
package status_led_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] LED_OFF   = 2'b00;
    localparam logic [MODE_W-1:0] LED_ON    = 2'b01;
    localparam logic [MODE_W-1:0] LED_BLINK = 2'b10;
    localparam logic [MODE_W-1:0] LED_PULSE = 2'b11;

endpackage

// File: rtl/led_channel.sv
// led_channel: one LED output of the status controller.
//
// Synchronises the asynchronous activity strobe, detects its rising edge, runs a
// retriggerable pulse counter in tick units, selects the lit condition from the
// channel mode, gates it with the PWM compare and the global blank, and registers
// the LED drive.
//
// Ports:
//   clk      in   module clock
//   rstn     in   synchronous active-low reset
//   tick     in   one-cycle tick strobe from the shared prescaler
//   startup  in   lamp-test window active; forces the LED on
//   blank    in   synchronised sleep request; forces the LED off outside lamp test
//   phase    in   shared blink phase (1 = lit half)
//   pwm_cnt  in   shared free-running PWM counter
//   mode     in   channel mode (LED_OFF / LED_ON / LED_BLINK / LED_PULSE)
//   duty     in   channel brightness
//   evt      in   asynchronous activity strobe, level or pulse
//   led      out  registered LED drive, 1 = on
module led_channel
    import status_led_pkg::*;
#(
    parameter int unsigned PULSE_TICKS = 50,
    parameter int unsigned PWM_BITS    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                tick,
    input  logic                startup,
    input  logic                blank,
    input  logic                phase,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [MODE_W-1:0]   mode,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                evt,
    output logic                led
);

    localparam int unsigned PW = (PULSE_TICKS > 0) ? $clog2(PULSE_TICKS + 1) : 1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   rise;
    logic [PW-1:0]          pulse_cnt;
    logic                   pulse_on;
    logic                   pwm_on;
    logic                   lit;

    assign pulse_on = (pulse_cnt != '0);

    // Full-scale duty means constantly on; otherwise the compare can never
    // reach 100% because pwm_cnt tops out at the same all-ones value.
    always_comb begin
        pwm_on = 1'b0;
        if (duty == '1) begin
            pwm_on = 1'b1;
        end else begin
            pwm_on = (pwm_cnt < duty);
        end
    end

    always_comb begin
        lit = 1'b0;
        unique case (mode)
            LED_OFF:   lit = 1'b0;
            LED_ON:    lit = 1'b1;
            LED_BLINK: lit = phase;
            LED_PULSE: lit = pulse_on;
            default:   lit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync      <= '0;
            prev      <= 1'b0;
            rise      <= 1'b0;
            pulse_cnt <= '0;
            led       <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], evt};
            prev <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~prev;
            // A fresh edge reloads even if a tick lands in the same cycle.
            if (rise) begin
                pulse_cnt <= PW'(PULSE_TICKS);
            end else if (tick && pulse_on) begin
                pulse_cnt <= pulse_cnt - PW'(1);
            end
            led <= startup | (~blank & lit & pwm_on);
        end
    end

endmodule

// File: rtl/status_led_ctrl.sv
// status_led_ctrl: multi-channel LED status controller.
//
// Shared logic (tick prescaler, lamp-test counter, blink phase, PWM counter,
// sleep synchroniser) lives here; per-channel event handling, mode select and
// the output flop live in led_channel, instantiated once per channel.
//
// Ports:
//   clk_i      in   module clock
//   rstn_i     in   synchronous active-low reset
//   mode_i     in   per-channel mode, channel k uses [2k+1:2k]
//   duty_i     in   per-channel brightness, channel k uses [PWM_BITS*k +: PWM_BITS]
//   event_i    in   asynchronous per-channel activity strobes
//   sleep_i    in   asynchronous global blank request
//   led_o      out  registered LED drive, 1 = on
//   tick_o     out  one-cycle pulse per tick
//   startup_o  out  high while the lamp-test window is active
module status_led_ctrl
    import status_led_pkg::*;
#(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned TICK_DIV      = 1000,
    parameter int unsigned BLINK_TICKS   = 250,
    parameter int unsigned PULSE_TICKS   = 50,
    parameter int unsigned STARTUP_TICKS = 1000,
    parameter int unsigned PWM_BITS      = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [MODE_W*CHANNELS-1:0]   mode_i,
    input  logic [PWM_BITS*CHANNELS-1:0] duty_i,
    input  logic [CHANNELS-1:0]          event_i,
    input  logic                         sleep_i,
    output logic [CHANNELS-1:0]          led_o,
    output logic                         tick_o,
    output logic                         startup_o
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (STARTUP_TICKS > 0) ? $clog2(STARTUP_TICKS + 1) : 1;
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [TW-1:0]          tick_cnt;
    logic [SW-1:0]          startup_cnt;
    logic [BW-1:0]          blink_cnt;
    logic                   phase;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic [SYNC_STAGES-1:0] sleep_sync;
    logic                   blank;
    logic                   tick;
    logic                   startup;

    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign startup   = (startup_cnt != '0);
    assign tick_o    = tick;
    assign startup_o = startup;

    // Tick prescaler and free-running PWM counter; neither pauses for sleep.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tick_cnt <= '0;
            pwm_cnt  <= '0;
        end else begin
            if (tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Lamp-test window: counts down ticks from reset, then holds at zero.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            startup_cnt <= SW'(STARTUP_TICKS);
        end else if (tick && startup) begin
            startup_cnt <= startup_cnt - SW'(1);
        end
    end

    // Sleep synchroniser plus one retiming flop. The blink counter freezes on
    // the same registered value that blanks the outputs, so the phase resumes
    // exactly where the LEDs went dark.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sleep_sync <= '0;
            blank      <= 1'b0;
        end else begin
            sleep_sync <= {sleep_sync[SYNC_STAGES-2:0], sleep_i};
            blank      <= sleep_sync[SYNC_STAGES-1];
        end
    end

    // Blink phase: toggles every BLINK_TICKS ticks, starts dark.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick && !blank) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        led_channel #(
            .PULSE_TICKS (PULSE_TICKS),
            .PWM_BITS    (PWM_BITS),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk     (clk_i),
            .rstn    (rstn_i),
            .tick    (tick),
            .startup (startup),
            .blank   (blank),
            .phase   (phase),
            .pwm_cnt (pwm_cnt),
            .mode    (mode_i[MODE_W*k +: MODE_W]),
            .duty    (duty_i[PWM_BITS*k +: PWM_BITS]),
            .evt     (event_i[k]),
            .led     (led_o[k])
        );
    end

endmodule

// File: tb/tb_status_led_ctrl.sv
// tb_status_led_ctrl: directed self-checking bench for status_led_ctrl.
//
// Small parameters (TICK_DIV=4, BLINK_TICKS=3, PULSE_TICKS=5, STARTUP_TICKS=8,
// PWM_BITS=2, SYNC_STAGES=2, CHANNELS=2). Inputs change and outputs are sampled
// on the falling edge; edge_no counts rising edges since the last reset release,
// so "after En" means just after the n-th rising edge with rstn_i high.
module tb_status_led_ctrl;

    logic       clk = 1'b0;
    logic       rstn_i;
    logic [3:0] mode_i;
    logic [3:0] duty_i;
    logic [1:0] event_i;
    logic       sleep_i;
    logic [1:0] led_o;
    logic       tick_o;
    logic       startup_o;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_no  = 0;

    always #5 clk = ~clk;

    status_led_ctrl #(
        .CHANNELS      (2),
        .TICK_DIV      (4),
        .BLINK_TICKS   (3),
        .PULSE_TICKS   (5),
        .STARTUP_TICKS (8),
        .PWM_BITS      (2),
        .SYNC_STAGES   (2)
    ) u_dut (
        .clk_i     (clk),
        .rstn_i    (rstn_i),
        .mode_i    (mode_i),
        .duty_i    (duty_i),
        .event_i   (event_i),
        .sleep_i   (sleep_i),
        .led_o     (led_o),
        .tick_o    (tick_o),
        .startup_o (startup_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    // Advance to the falling edge that follows rising edge e.
    task automatic go(input int e);
        while (edge_no < e) begin
            @(negedge clk);
            edge_no++;
        end
    endtask

    task automatic release_reset();
        rstn_i  = 1'b1;
        edge_no = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sum;
        int pwm_exp [4] = '{0, 1, 2, 4};

        rstn_i  = 1'b0;
        mode_i  = 4'b0000;
        duty_i  = 4'b1111;
        event_i = 2'b00;
        sleep_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led", led_o, 2'b00);
        check("rst_tick", tick_o, 1'b0);
        check("rst_startup", startup_o, 1'b1);
        release_reset();

        // Lamp test: 8 ticks of 4 cycles, LEDs one cycle behind startup_o.
        go(1);  check("lt_led_e1", led_o, 2'b11);
        check("lt_startup_e1", startup_o, 1'b1);
        check("lt_tick_e1", tick_o, 1'b0);
        go(3);  check("tick_e3", tick_o, 1'b1);
        go(4);  check("tick_e4", tick_o, 1'b0);
        go(31); check("lt_startup_e31", startup_o, 1'b1);
        check("tick_e31", tick_o, 1'b1);
        go(32); check("lt_startup_e32", startup_o, 1'b0);
        check("lt_led_e32", led_o, 2'b11);
        go(33); check("lt_led_e33", led_o, 2'b00);

        // ch0 BLINK, duty 3: phase flips at E36, E48, E60.
        mode_i = 4'b0010;
        go(36); check("blink_e36", led_o[0], 1'b0);
        go(37); check("blink_e37", led_o[0], 1'b1);
        go(48); check("blink_e48", led_o[0], 1'b1);
        go(49); check("blink_e49", led_o[0], 1'b0);
        go(60); check("blink_e60", led_o[0], 1'b0);
        go(61); check("blink_e61", led_o[0], 1'b1);

        // Sleep for 10 ticks, sampled E63..E102.
        go(62); sleep_i = 1'b1;
        go(65); check("sleep_e65", led_o[0], 1'b1);
        go(66); check("sleep_e66", led_o[0], 1'b0);
        go(67); check("sleep_tick_e67", tick_o, 1'b1);
        go(90); check("sleep_e90", led_o[0], 1'b0);
        go(102); sleep_i = 1'b0;
        go(105); check("wake_e105", led_o[0], 1'b0);
        go(106); check("wake_e106", led_o[0], 1'b1);
        go(112); check("wake_e112", led_o[0], 1'b1);
        go(113); check("wake_e113", led_o[0], 1'b0);

        // ch1 PULSE, single event sampled at E115: lit E119..E136.
        mode_i = 4'b1100;
        go(114); event_i = 2'b10;
        go(115); event_i = 2'b00;
        go(118); check("pulse_e118", led_o[1], 1'b0);
        go(119); check("pulse_e119", led_o[1], 1'b1);
        go(136); check("pulse_e136", led_o[1], 1'b1);
        go(137); check("pulse_e137", led_o[1], 1'b0);

        // Second pulse loaded at E144; retrigger load lands on tick edge E156.
        go(140); event_i = 2'b10;
        go(141); event_i = 2'b00;
        go(145); check("retrig_e145", led_o[1], 1'b1);
        go(152); event_i = 2'b10;
        go(153); event_i = 2'b00;
        go(165); check("retrig_e165", led_o[1], 1'b1);
        go(172); check("retrig_e172", led_o[1], 1'b1);
        go(176); check("retrig_e176", led_o[1], 1'b1);
        go(177); check("retrig_e177", led_o[1], 1'b0);

        // ch0 ON, duty sweep: on-cycles per 4-cycle PWM period.
        go(180);
        mode_i = 4'b0001;
        for (int d = 0; d < 4; d++) begin
            duty_i = {2'b11, 2'(d)};
            go(edge_no + 2);
            sum = 0;
            for (int i = 0; i < 4; i++) begin
                go(edge_no + 1);
                sum += int'(led_o[0]);
            end
            check($sformatf("pwm_duty%0d", d), sum, pwm_exp[d]);
        end

        // Mid-pulse, mid-blink reset.
        go(220);
        mode_i  = 4'b1110;
        duty_i  = 4'b1111;
        event_i = 2'b10;
        go(221); event_i = 2'b00;
        go(226); check("pre_rst_pulse", led_o[1], 1'b1);
        rstn_i = 1'b0;
        @(negedge clk);
        check("mid_rst_led", led_o, 2'b00);
        check("mid_rst_tick", tick_o, 1'b0);
        check("mid_rst_startup", startup_o, 1'b1);
        release_reset();
        go(1);  check("rlt_led_e1", led_o, 2'b11);
        go(31); check("rlt_startup_e31", startup_o, 1'b1);
        go(32); check("rlt_startup_e32", startup_o, 1'b0);
        check("rlt_led_e32", led_o, 2'b11);
        go(33); check("rlt_led_e33", led_o, 2'b00);
        go(35); check("rlt_led_e35", led_o, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
